ofs_plat_host_chan_tx_tlp_arb: RTL and testbench

//  Shares the host-channel TX TLP port between the read-request TLP generator and the write/fence TLP generator.

---
 rtl/ofs_plat_host_chan_tx_tlp_arb_pkg.sv | 28 ++
 rtl/ofs_plat_host_chan_tx_tlp_arb_if.sv | 68 ++++++
 rtl/ofs_plat_host_chan_tx_tlp_arb_pick.sv | 62 ++++++
 rtl/ofs_plat_host_chan_tx_tlp_arb.sv | 146 ++++++++++++++
 tb/tb_ofs_plat_host_chan_tx_tlp_arb.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ofs_plat_host_chan_tx_tlp_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ofs_plat_host_chan_tx_arb_pkg
// Brief    : Shared types and the credit-width helper for the host-channel TX
//            TLP arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ofs_plat_host_chan_tx_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_LOCK_RD = 2'd1,
      ARB_LOCK_WR = 2'd2
   } t_arb_state;

   typedef enum logic {
      SRC_RD = 1'b0,
      SRC_WR = 1'b1
   } t_arb_src;

   function automatic int arb_credit_w(input int rd_weight, input int wr_weight);
      int max_w;
      max_w = (rd_weight > wr_weight) ? rd_weight : wr_weight;
      return $clog2(max_w + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ofs_plat_host_chan_tx_tlp_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : ofs_plat_host_chan_tx_tlp_arb_if
// Brief    : Read, write/fence and TX stream signals of the TX TLP arbiter.
//            Stats ports exist only with OFS_PLAT_HOST_CHAN_TX_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface ofs_plat_host_chan_tx_tlp_arb_if
#(
   parameter int TDATA_W = 512
`ifdef OFS_PLAT_HOST_CHAN_TX_ARB_STATS_EN
   , parameter int CNT_W = 32
`endif
);
   logic               rd_tvalid;
   logic               rd_tready;
   logic [TDATA_W-1:0] rd_tdata;
   logic               rd_sop;
   logic               rd_eop;

   logic               wr_tvalid;
   logic               wr_tready;
   logic [TDATA_W-1:0] wr_tdata;
   logic               wr_sop;
   logic               wr_eop;

   logic               out_tvalid;
   logic               out_tready;
   logic [TDATA_W-1:0] out_tdata;
   logic               out_sop;
   logic               out_eop;
   logic               out_is_wr;
   logic               error;

`ifdef OFS_PLAT_HOST_CHAN_TX_ARB_STATS_EN
   logic [CNT_W-1:0]   stat_rd_pkts;
   logic [CNT_W-1:0]   stat_wr_pkts;
   logic [CNT_W-1:0]   stat_stall_cycles;
`endif

   // Generators and TX sink side
   modport master (
      output rd_tvalid, rd_tdata, rd_sop, rd_eop,
      input  rd_tready,
      output wr_tvalid, wr_tdata, wr_sop, wr_eop,
      input  wr_tready,
      input  out_tvalid, out_tdata, out_sop, out_eop, out_is_wr, error,
      output out_tready
`ifdef OFS_PLAT_HOST_CHAN_TX_ARB_STATS_EN
      , input stat_rd_pkts, stat_wr_pkts, stat_stall_cycles
`endif
   );

   // Arbiter side
   modport slave (
      input  rd_tvalid, rd_tdata, rd_sop, rd_eop,
      output rd_tready,
      input  wr_tvalid, wr_tdata, wr_sop, wr_eop,
      output wr_tready,
      output out_tvalid, out_tdata, out_sop, out_eop, out_is_wr, error,
      input  out_tready
`ifdef OFS_PLAT_HOST_CHAN_TX_ARB_STATS_EN
      , output stat_rd_pkts, stat_wr_pkts, stat_stall_cycles
`endif
   );

endinterface
`default_nettype wire

// File: rtl/ofs_plat_host_chan_tx_tlp_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : ofs_plat_host_chan_tx_arb_pick
// Brief    : Weighted round-robin source pick used while the arbiter is idle,
//            plus the last-source / credit registers behind it.
// Revision : 1.0 - initial release
// ============================================================================
module ofs_plat_host_chan_tx_arb_pick
   import ofs_plat_host_chan_tx_arb_pkg::*;
#(
   parameter int RD_WEIGHT = 1,
   parameter int WR_WEIGHT = 4
)
(
   input  logic     clk,
   input  logic     reset_n,
   input  logic     rd_valid,
   input  logic     wr_valid,
   input  logic     sop_accept,
   output t_arb_src pick
);
   localparam int                  c_cred_w = arb_credit_w(RD_WEIGHT, WR_WEIGHT);
   localparam logic [c_cred_w-1:0] c_rd_wt  = c_cred_w'(RD_WEIGHT);
   localparam logic [c_cred_w-1:0] c_wr_wt  = c_cred_w'(WR_WEIGHT);

   t_arb_src            r_last_src;
   logic [c_cred_w-1:0] r_credit;
   logic [c_cred_w-1:0] w_last_wt;
   t_arb_src            w_pref;

   assign w_last_wt = (r_last_src == SRC_RD) ? c_rd_wt : c_wr_wt;

   always_comb begin
      // Zero credit only exists straight out of reset (no history), so the
      // source other than last_src (reads) takes the first tie.
      if ((r_credit != '0) && (r_credit < w_last_wt))
         w_pref = r_last_src;
      else
         w_pref = (r_last_src == SRC_RD) ? SRC_WR : SRC_RD;

      pick = w_pref;
      if (rd_valid && !wr_valid)
         pick = SRC_RD;
      else if (wr_valid && !rd_valid)
         pick = SRC_WR;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_src <= SRC_WR;
         r_credit   <= '0;
      end else if (sop_accept) begin
         r_last_src <= pick;
         if (pick != r_last_src)
            r_credit <= c_cred_w'(1);
         else if (r_credit < w_last_wt)
            r_credit <= r_credit + c_cred_w'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/ofs_plat_host_chan_tx_tlp_arb.sv
`default_nettype none
// ============================================================================
// Module   : ofs_plat_host_chan_tx_tlp_arb
// Brief    : Packet-atomic weighted round-robin arbiter sharing the TX TLP port
//            between read and write/fence generators, one registered stage.
//            Optional counters: OFS_PLAT_HOST_CHAN_TX_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ofs_plat_host_chan_tx_tlp_arb
   import ofs_plat_host_chan_tx_arb_pkg::*;
#(
   parameter int TDATA_W   = 512,
   parameter int RD_WEIGHT = 1,
   parameter int WR_WEIGHT = 4
`ifdef OFS_PLAT_HOST_CHAN_TX_ARB_STATS_EN
   , parameter int CNT_W   = 32
`endif
)
(
   input  logic                            clk,
   input  logic                            reset_n,
   ofs_plat_host_chan_tx_tlp_arb_if.slave  bus
);
   t_arb_state         r_state;
   logic               r_out_valid;
   logic [TDATA_W-1:0] r_out_data;
   logic               r_out_sop;
   logic               r_out_eop;
   logic               r_out_is_wr;
   logic               r_error;

   logic               w_load;
   t_arb_src           w_pick;
   t_arb_src           w_grant;
   logic               w_fire;
   logic [TDATA_W-1:0] w_data;
   logic               w_sop;
   logic               w_eop;
   logic               w_sop_accept;

   assign w_load = !r_out_valid || bus.out_tready;

   always_comb begin
      w_grant = w_pick;
      case (r_state)
         ARB_LOCK_RD: w_grant = SRC_RD;
         ARB_LOCK_WR: w_grant = SRC_WR;
         default:     w_grant = w_pick;
      endcase
   end

   assign bus.rd_tready = w_load && (w_grant == SRC_RD);
   assign bus.wr_tready = w_load && (w_grant == SRC_WR);

   assign w_fire = (w_grant == SRC_RD) ? (bus.rd_tvalid && bus.rd_tready)
                                       : (bus.wr_tvalid && bus.wr_tready);
   assign w_data = (w_grant == SRC_RD) ? bus.rd_tdata : bus.wr_tdata;
   assign w_sop  = (w_grant == SRC_RD) ? bus.rd_sop   : bus.wr_sop;
   assign w_eop  = (w_grant == SRC_RD) ? bus.rd_eop   : bus.wr_eop;

   assign w_sop_accept = (r_state == ARB_IDLE) && w_fire && w_sop;

   ofs_plat_host_chan_tx_arb_pick #(
      .RD_WEIGHT (RD_WEIGHT),
      .WR_WEIGHT (WR_WEIGHT)
   ) u_pick (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_valid   (bus.rd_tvalid),
      .wr_valid   (bus.wr_tvalid),
      .sop_accept (w_sop_accept),
      .pick       (w_pick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ARB_IDLE;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
         r_out_is_wr <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         if (w_fire) begin
            case (r_state)
               ARB_IDLE: begin
                  if (!w_sop)
                     r_error <= 1'b1;
                  // A single-beat packet never locks
                  if (!w_eop)
                     r_state <= (w_grant == SRC_RD) ? ARB_LOCK_RD : ARB_LOCK_WR;
               end
               default: begin
                  if (w_sop)
                     r_error <= 1'b1;
                  if (w_eop)
                     r_state <= ARB_IDLE;
               end
            endcase
         end

         if (w_load) begin
            r_out_valid <= w_fire;
            r_out_data  <= w_data;
            r_out_sop   <= w_fire && w_sop;
            r_out_eop   <= w_fire && w_eop;
            r_out_is_wr <= w_fire && (w_grant == SRC_WR);
         end
      end
   end

   assign bus.out_tvalid = r_out_valid;
   assign bus.out_tdata  = r_out_data;
   assign bus.out_sop    = r_out_sop;
   assign bus.out_eop    = r_out_eop;
   assign bus.out_is_wr  = r_out_is_wr;
   assign bus.error      = r_error;

`ifdef OFS_PLAT_HOST_CHAN_TX_ARB_STATS_EN
   logic [CNT_W-1:0] r_stat_rd_pkts;
   logic [CNT_W-1:0] r_stat_wr_pkts;
   logic [CNT_W-1:0] r_stat_stall_cycles;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stat_rd_pkts      <= '0;
         r_stat_wr_pkts      <= '0;
         r_stat_stall_cycles <= '0;
      end else begin
         if (bus.rd_tvalid && bus.rd_tready && bus.rd_eop)
            r_stat_rd_pkts <= r_stat_rd_pkts + CNT_W'(1);
         if (bus.wr_tvalid && bus.wr_tready && bus.wr_eop)
            r_stat_wr_pkts <= r_stat_wr_pkts + CNT_W'(1);
         if (r_out_valid && !bus.out_tready)
            r_stat_stall_cycles <= r_stat_stall_cycles + CNT_W'(1);
      end
   end

   assign bus.stat_rd_pkts      = r_stat_rd_pkts;
   assign bus.stat_wr_pkts      = r_stat_wr_pkts;
   assign bus.stat_stall_cycles = r_stat_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ofs_plat_host_chan_tx_tlp_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofs_plat_host_chan_tx_tlp_arb
// Brief    : Randomized bench for the TX TLP arbiter with a behavioural model
//            of the arbitration and output-register rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofs_plat_host_chan_tx_tlp_arb;

   localparam int TDATA_W   = 64;
   localparam int RD_WEIGHT = 1;
   localparam int WR_WEIGHT = 4;

   typedef struct {
      logic [TDATA_W-1:0] data;
      bit                 sop;
      bit                 eop;
   } beat_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   always #5 clk = ~clk;

   ofs_plat_host_chan_tx_tlp_arb_if #(.TDATA_W(TDATA_W)) bus ();

   ofs_plat_host_chan_tx_tlp_arb #(
      .TDATA_W   (TDATA_W),
      .RD_WEIGHT (RD_WEIGHT),
      .WR_WEIGHT (WR_WEIGHT)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [TDATA_W-1:0] obs,
                        input logic [TDATA_W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Source packet queues and driver hold state
   beat_t rd_q[$];
   beat_t wr_q[$];
   bit    rd_hold, wr_hold;
   int    obs_q[$];   // out_is_wr of each beat consumed by the sink

   // Reference model: lock 0=idle,1=rd,2=wr; src 0=rd,1=wr
   int                 m_lock, m_last, m_credit;
   bit                 m_err, m_ov, m_osop, m_oeop, m_owr;
   logic [TDATA_W-1:0] m_od;

   function automatic int weight(input int src);
      return (src == 0) ? RD_WEIGHT : WR_WEIGHT;
   endfunction

   function automatic int model_pick(input bit rv, input bit wv);
      int pref;
      // credit 0 means no history since reset: the other source goes first
      pref = (m_credit != 0 && m_credit < weight(m_last)) ? m_last : 1 - m_last;
      if (rv && !wv) return 0;
      if (wv && !rv) return 1;
      return pref;
   endfunction

   task automatic push_pkt(input int src, input int len, input bit with_sop);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = {$urandom(), $urandom()};
         b.sop  = with_sop && (i == 0);
         b.eop  = (i == len - 1);
         if (src == 0) rd_q.push_back(b);
         else          wr_q.push_back(b);
      end
   endtask

   task automatic drive_idle();
      bus.rd_tvalid  = 1'b0;  bus.rd_tdata = '0;  bus.rd_sop = 1'b0;  bus.rd_eop = 1'b0;
      bus.wr_tvalid  = 1'b0;  bus.wr_tdata = '0;  bus.wr_sop = 1'b0;  bus.wr_eop = 1'b0;
      bus.out_tready = 1'b0;
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic cycle(input int rd_pct, input int wr_pct, input int rdy_pct);
      beat_t rb, wb, b;
      bit    rv, wv, rdy, ld, exp_r, exp_w, fire, rd_fire, wr_fire;
      int    g;

      check("out_tvalid", bus.out_tvalid, m_ov);
      if (m_ov) begin
         check("out_tdata", bus.out_tdata, m_od);
         check("out_sop", bus.out_sop, m_osop);
         check("out_eop", bus.out_eop, m_oeop);
         check("out_is_wr", bus.out_is_wr, m_owr);
      end
      check("error", bus.error, m_err);

      rv = rd_hold || (rd_q.size() > 0 && $urandom_range(99) < rd_pct);
      wv = wr_hold || (wr_q.size() > 0 && $urandom_range(99) < wr_pct);
      rb = rv ? rd_q[0] : '{data: {$urandom(), $urandom()}, sop: 1'b0, eop: 1'b0};
      wb = wv ? wr_q[0] : '{data: {$urandom(), $urandom()}, sop: 1'b0, eop: 1'b0};
      bus.rd_tvalid = rv;  bus.rd_tdata = rb.data;  bus.rd_sop = rb.sop;  bus.rd_eop = rb.eop;
      bus.wr_tvalid = wv;  bus.wr_tdata = wb.data;  bus.wr_sop = wb.sop;  bus.wr_eop = wb.eop;
      rdy = ($urandom_range(99) < rdy_pct);
      bus.out_tready = rdy;
      if (bus.out_tvalid && rdy) obs_q.push_back(int'(bus.out_is_wr));
      #1;

      ld = !m_ov || rdy;
      if (m_lock == 1)      g = 0;
      else if (m_lock == 2) g = 1;
      else                  g = model_pick(rv, wv);
      exp_r = ld && (g == 0);
      exp_w = ld && (g == 1);
      if (rv) check("rd_tready", bus.rd_tready, exp_r);
      if (wv) check("wr_tready", bus.wr_tready, exp_w);
      check("tready_excl", bus.rd_tready & bus.wr_tready, 1'b0);

      b    = (g == 0) ? rb : wb;
      fire = (g == 0) ? (exp_r && rv) : (exp_w && wv);
      if (fire) begin
         if (m_lock == 0) begin
            if (!b.sop) m_err = 1'b1;
            else begin
               if (g == m_last) m_credit = (m_credit + 1 > weight(g)) ? weight(g) : m_credit + 1;
               else             m_credit = 1;
               m_last = g;
            end
            if (!b.eop) m_lock = g + 1;
         end else begin
            if (b.sop) m_err = 1'b1;
            if (b.eop) m_lock = 0;
         end
      end
      if (ld) begin
         m_ov = fire;  m_od = b.data;  m_osop = b.sop;  m_oeop = b.eop;  m_owr = (g == 1);
      end

      rd_fire = rv && bus.rd_tready;  rd_hold = rv && !bus.rd_tready;
      wr_fire = wv && bus.wr_tready;  wr_hold = wv && !bus.wr_tready;
      @(posedge clk);
      if (rd_fire) void'(rd_q.pop_front());
      if (wr_fire) void'(wr_q.pop_front());
      @(negedge clk);
   endtask

   // Asserted asynchronously between edges, released on a negedge.
   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      check("rst_out_tvalid", bus.out_tvalid, 1'b0);
      check("rst_out_sop", bus.out_sop, 1'b0);
      check("rst_out_eop", bus.out_eop, 1'b0);
      check("rst_out_is_wr", bus.out_is_wr, 1'b0);
      check("rst_error", bus.error, 1'b0);
      rd_q.delete();  wr_q.delete();  obs_q.delete();
      rd_hold = 1'b0;  wr_hold = 1'b0;
      drive_idle();
      m_lock = 0;  m_last = 1;  m_credit = 0;  m_err = 1'b0;  m_ov = 1'b0;
      m_od = '0;  m_osop = 1'b0;  m_oeop = 1'b0;  m_owr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic check_seq(input string tag, input int exp[$]);
      check({tag, "_len"}, TDATA_W'(obs_q.size()), TDATA_W'(exp.size()));
      for (int i = 0; i < exp.size() && i < obs_q.size(); i++)
         check(tag, TDATA_W'(obs_q[i]), TDATA_W'(exp[i]));
   endtask

   initial begin
      int n;
      drive_idle();
      @(negedge clk);
      do_reset();

      // Reads only: 8 single-beat packets, full rate
      for (int i = 0; i < 8; i++) push_pkt(0, 1, 1'b1);
      repeat (10) cycle(100, 0, 100);
      check_seq("rd_only", '{0, 0, 0, 0, 0, 0, 0, 0});

      // Atomicity: 4-beat write, reads valid from the next cycle
      obs_q.delete();
      push_pkt(1, 4, 1'b1);
      cycle(100, 100, 100);
      push_pkt(0, 1, 1'b1);
      push_pkt(0, 1, 1'b1);
      repeat (8) cycle(100, 100, 100);
      check_seq("atomic", '{1, 1, 1, 1, 0, 0});

      // Weights 1/4 with both sources saturated
      do_reset();
      for (int i = 0; i < 10; i++) push_pkt(0, 1, 1'b1);
      for (int i = 0; i < 20; i++) push_pkt(1, 1, 1'b1);
      repeat (40) cycle(100, 100, 100);
      obs_q = obs_q[0:9];
      check_seq("wrr", '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1});

      // Backpressure mid write packet
      obs_q.delete();
      push_pkt(1, 6, 1'b1);
      push_pkt(0, 1, 1'b1);
      repeat (2) cycle(100, 100, 100);
      repeat (5) cycle(100, 100, 0);
      repeat (10) cycle(100, 100, 100);
      check_seq("bp", '{1, 1, 1, 1, 1, 1, 0});

      // Protocol error: read beat without sop while idle
      obs_q.delete();
      push_pkt(0, 1, 1'b0);
      repeat (4) cycle(100, 100, 100);
      check("err_sticky", bus.error, 1'b1);
      check_seq("err_fwd", '{0});

      // Randomized traffic with random gaps and backpressure
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         if (rd_q.size() < 6) push_pkt(0, $urandom_range(1, 4), 1'b1);
         if (wr_q.size() < 6) push_pkt(1, $urandom_range(1, 4), 1'b1);
         cycle(60, 60, 75);
      end
      n = 0;
      while (n < 300 && (rd_q.size() > 0 || wr_q.size() > 0 || m_ov)) begin
         cycle(100, 100, 100);
         n++;
      end
      check("drain_done", TDATA_W'(rd_q.size() + wr_q.size()), '0);

      // Async reset mid-packet, then a fresh read packet
      push_pkt(1, 4, 1'b1);
      repeat (2) cycle(100, 100, 100);
      do_reset();
      push_pkt(0, 2, 1'b1);
      repeat (4) cycle(100, 100, 100);
      check_seq("post_rst", '{0, 0});

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
